instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 128 ++++++++++++
 tb/tb_instr_encoder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Two-stage RISC-V instruction encoder: S1 captures the request and its range/format
// check, S2 holds the packed word (or NOP on error) until the downstream handshake.
module instr_encoder (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  input  logic        flush_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] instr_o,
  output logic        err_o,
  output logic [15:0] err_count_o
);
  localparam int          STAGES = 2;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [2:0]  FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2,
                          FMT_B = 3'd3, FMT_U = 3'd4, FMT_J = 3'd5;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        err;
  } s1_t;

  logic [STAGES-1:0] vld_pipe_q, vld_pipe_d;
  s1_t               s1_q, s1_d;
  logic [31:0]       instr_q, asm_instr;
  logic              err_q;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic              adv, acc, chk_err;
  logic [20:0]       hi11;
  logic [19:0]       hi12;
  logic [11:0]       hi20;

  assign adv        = !vld_pipe_q[STAGES-1] || out_ready_i;
  assign in_ready_o = adv && !flush_i;
  assign acc        = in_valid_i && in_ready_o;

  // Immediate fits when all bits above the field's sign bit replicate it.
  assign hi11 = imm_i[31:11];
  assign hi12 = imm_i[31:12];
  assign hi20 = imm_i[31:20];

  always_comb begin
    chk_err = 1'b0;
    case (fmt_i)
      FMT_R:        chk_err = 1'b0;
      FMT_I, FMT_S: chk_err = !((&hi11) || !(|hi11));
      FMT_B:        chk_err = !((&hi12) || !(|hi12)) || imm_i[0];
      FMT_U:        chk_err = |imm_i[11:0];
      FMT_J:        chk_err = !((&hi20) || !(|hi20)) || imm_i[0];
      default:      chk_err = 1'b1;
    endcase
  end

  always_comb begin
    s1_d = '{fmt: fmt_i, opcode: opcode_i, rd: rd_i, rs1: rs1_i, rs2: rs2_i,
             funct3: funct3_i, funct7: funct7_i, imm: imm_i, err: chk_err};
  end

  always_comb begin
    asm_instr = NOP;
    case (s1_q.fmt)
      FMT_R: asm_instr = {s1_q.funct7, s1_q.rs2, s1_q.rs1, s1_q.funct3, s1_q.rd, s1_q.opcode};
      FMT_I: asm_instr = {s1_q.imm[11:0], s1_q.rs1, s1_q.funct3, s1_q.rd, s1_q.opcode};
      FMT_S: asm_instr = {s1_q.imm[11:5], s1_q.rs2, s1_q.rs1, s1_q.funct3, s1_q.imm[4:0],
                          s1_q.opcode};
      FMT_B: asm_instr = {s1_q.imm[12], s1_q.imm[10:5], s1_q.rs2, s1_q.rs1, s1_q.funct3,
                          s1_q.imm[4:1], s1_q.imm[11], s1_q.opcode};
      FMT_U: asm_instr = {s1_q.imm[31:12], s1_q.rd, s1_q.opcode};
      FMT_J: asm_instr = {s1_q.imm[20], s1_q.imm[10:1], s1_q.imm[11], s1_q.imm[19:12],
                          s1_q.rd, s1_q.opcode};
      default: asm_instr = NOP;
    endcase
    if (s1_q.err) asm_instr = NOP;
  end

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    if (flush_i)  vld_pipe_d = '0;
    else if (adv) vld_pipe_d = {vld_pipe_q[STAGES-2:0], acc};
  end

  // A flushed word is never counted, even if the consumer was ready.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (!flush_i && vld_pipe_q[STAGES-1] && out_ready_i && err_q && (err_cnt_q != 16'hFFFF))
      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      instr_q    <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      err_cnt_q  <= err_cnt_d;
      if (adv && !flush_i) begin
        s1_q    <= s1_d;
        instr_q <= asm_instr;
        err_q   <= s1_q.err;
      end
    end
  end

  assign out_valid_o = vld_pipe_q[STAGES-1];
  assign instr_o     = instr_q;
  assign err_o       = err_q;
  assign err_count_o = err_cnt_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Randomized scoreboard bench for instr_encoder: driver pushes expected words on
// acceptance, an independent monitor pops and compares on each output handshake.
module tb_instr_encoder;
  logic        clk = 1'b0;
  logic        rst_ni, in_valid_i, in_ready_o, flush_i, out_valid_o, out_ready_i, err_o;
  logic [2:0]  fmt_i, funct3_i;
  logic [6:0]  opcode_i, funct7_i;
  logic [4:0]  rd_i, rs1_i, rs2_i;
  logic [31:0] imm_i, instr_o;
  logic [15:0] err_count_o;

  instr_encoder dut (
    .clk_i(clk), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .fmt_i(fmt_i), .opcode_i(opcode_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .funct3_i(funct3_i), .funct7_i(funct7_i), .imm_i(imm_i), .flush_i(flush_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .instr_o(instr_o),
    .err_o(err_o), .err_count_o(err_count_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] fmt; logic [6:0] opc; logic [4:0] rd, rs1, rs2;
    logic [2:0] f3; logic [6:0] f7; logic [31:0] imm;
  } req_t;
  typedef struct { logic [31:0] instr; logic err; int cyc; } exp_t;

  exp_t        sbq[$];
  int          checks = 0, errors = 0;
  int          cyc = 0, last_stall = -1;
  logic [15:0] exp_cnt = '0;
  int          bnd[13] = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096, -4098,
                           1048574, 1048576, -1048576, -1048578};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference: legality by signed range / alignment arithmetic, then field placement.
  function automatic logic [32:0] model(input req_t r);
    int s = $signed(r.imm);
    logic e = 1'b0;
    logic [31:0] w = 32'h13;
    case (r.fmt)
      3'd0: w = {r.f7, r.rs2, r.rs1, r.f3, r.rd, r.opc};
      3'd1: begin e = (s < -2048 || s > 2047); w = {r.imm[11:0], r.rs1, r.f3, r.rd, r.opc}; end
      3'd2: begin e = (s < -2048 || s > 2047);
                  w = {r.imm[11:5], r.rs2, r.rs1, r.f3, r.imm[4:0], r.opc}; end
      3'd3: begin e = (s < -4096 || s > 4095 || (r.imm % 2) != 0);
                  w = {r.imm[12], r.imm[10:5], r.rs2, r.rs1, r.f3, r.imm[4:1], r.imm[11], r.opc}; end
      3'd4: begin e = (r.imm % 32'd4096) != 0; w = {r.imm[31:12], r.rd, r.opc}; end
      3'd5: begin e = (s < -1048576 || s > 1048575 || (r.imm % 2) != 0);
                  w = {r.imm[20], r.imm[10:1], r.imm[11], r.imm[19:12], r.rd, r.opc}; end
      default: e = 1'b1;
    endcase
    if (e) w = 32'h0000_0013;
    return {e, w};
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.fmt = 3'($urandom_range(0, 7)); r.opc = 7'($urandom); r.rd = 5'($urandom);
    r.rs1 = 5'($urandom); r.rs2 = 5'($urandom); r.f3 = 3'($urandom); r.f7 = 7'($urandom);
    case ($urandom_range(0, 5))
      0: r.imm = $urandom;
      1: r.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      2: r.imm = bnd[$urandom_range(0, 12)];
      3: r.imm = $urandom & 32'hFFFF_F000;
      4: r.imm = 32'($urandom_range(0, 2097151)) - 32'd1048576;
      default: r.imm = $urandom & 32'hFFFF_FFFE;
    endcase
    return r;
  endfunction

  task automatic drive(input logic rst, input logic v, input req_t r, input logic ordy,
                       input logic fl, input bit ovr, input logic [32:0] ev, output bit acc);
    exp_t e;
    logic [32:0] m;
    @(negedge clk);
    rst_ni = rst; in_valid_i = v; fmt_i = r.fmt; opcode_i = r.opc; rd_i = r.rd;
    rs1_i = r.rs1; rs2_i = r.rs2; funct3_i = r.f3; funct7_i = r.f7; imm_i = r.imm;
    out_ready_i = ordy; flush_i = fl;
    if (!ordy) last_stall = cyc;
    #1;
    acc = 1'b0;
    if (fl) sbq.delete();
    else if (rst && v && in_ready_o) begin
      m = ovr ? ev : model(r);
      e.instr = m[31:0]; e.err = m[32]; e.cyc = cyc;
      sbq.push_back(e);
      acc = 1'b1;
    end
  endtask

  task automatic idle(input logic rst, input logic ordy, input logic fl);
    bit a;
    drive(rst, 1'b0, '0, ordy, fl, 1'b0, '0, a);
  endtask

  task automatic send(input req_t r, input logic ordy, input bit ovr, input logic [32:0] ev);
    bit a = 1'b0;
    int n = 0;
    while (!a && n < 50) begin drive(1'b1, 1'b1, r, ordy, 1'b0, ovr, ev, a); n++; end
    chk("send_accepted", 32'(a), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 12; i++) idle(1'b1, 1'b1, 1'b0);
    chk("queue_drained", sbq.size(), 0);
  endtask

  // Monitor: reset values, held-output stability, in-order delivery, latency, error count.
  logic        held = 1'b0, h_err;
  logic [31:0] h_instr;
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst_ni) begin
      sbq.delete(); exp_cnt = '0; held = 1'b0;
      chk("rst_out_valid", 32'(out_valid_o), 0);
      chk("rst_instr", instr_o, 0);
      chk("rst_err", 32'(err_o), 0);
      chk("rst_err_count", 32'(err_count_o), 0);
      if (!flush_i) chk("rst_in_ready", 32'(in_ready_o), 1);
    end else begin
      chk("err_count", 32'(err_count_o), 32'(exp_cnt));
      if (held) begin
        chk("stall_valid", 32'(out_valid_o), 1);
        chk("stall_instr", instr_o, h_instr);
        chk("stall_err", 32'(err_o), 32'(h_err));
      end
      held = 1'b0;
      if (out_valid_o && out_ready_i) begin
        if (sbq.size() == 0) chk("spurious_word", 32'(out_valid_o), 0);
        else begin
          e = sbq.pop_front();
          chk("instr", instr_o, e.instr);
          chk("err", 32'(err_o), 32'(e.err));
          if (last_stall <= e.cyc) chk("latency", cyc - e.cyc, 2);
          if (e.err && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        end
      end else if (out_valid_o && !flush_i) begin
        held = 1'b1; h_instr = instr_o; h_err = err_o;
      end
    end
  end

  initial begin
    req_t r;
    bit a;
    logic [15:0] c;
    rst_ni = 1'b0; in_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b0;
    fmt_i = '0; opcode_i = '0; rd_i = '0; rs1_i = '0; rs2_i = '0;
    funct3_i = '0; funct7_i = '0; imm_i = '0;
    for (int i = 0; i < 3; i++) idle(1'b0, 1'b1, 1'b0);

    // First edge out of reset accepts; known-answer words.
    r = '{fmt: 3'd1, opc: 7'b0010011, rd: 5'd1, rs1: 5'd0, rs2: 5'd0, f3: 3'd0, f7: 7'd0, imm: 32'd5};
    drive(1'b1, 1'b1, r, 1'b1, 1'b0, 1'b1, {1'b0, 32'h00500093}, a);
    chk("first_edge_accept", 32'(a), 1);
    r = '{fmt: 3'd3, opc: 7'b1100011, rd: 5'd0, rs1: 5'd0, rs2: 5'd0, f3: 3'd0, f7: 7'd0, imm: 32'hFFFFFFFC};
    send(r, 1'b1, 1'b1, {1'b0, 32'hFE000EE3});
    r = '{fmt: 3'd4, opc: 7'b0110111, rd: 5'd5, rs1: 5'd0, rs2: 5'd0, f3: 3'd0, f7: 7'd0, imm: 32'h12345000};
    send(r, 1'b1, 1'b1, {1'b0, 32'h123452B7});
    r.imm = 32'h12345001;
    send(r, 1'b1, 1'b1, {1'b1, 32'h00000013});
    drain();
    chk("kat_err_count_1", 32'(err_count_o), 1);

    idle(1'b0, 1'b1, 1'b0);
    r = '{fmt: 3'd5, opc: 7'b1101111, rd: 5'd3, rs1: 5'd0, rs2: 5'd0, f3: 3'd0, f7: 7'd0, imm: 32'd3};
    send(r, 1'b1, 1'b1, {1'b1, 32'h00000013});
    r.fmt = 3'd7;
    send(r, 1'b1, 1'b1, {1'b1, 32'h00000013});
    drain();
    chk("kat_err_count_2", 32'(err_count_o), 2);

    // Backpressure: fill the pipe, stall 3 cycles, then release.
    r = rand_req(); drive(1'b1, 1'b1, r, 1'b0, 1'b0, 1'b0, '0, a); chk("bp_accept_a", 32'(a), 1);
    r = rand_req(); drive(1'b1, 1'b1, r, 1'b0, 1'b0, 1'b0, '0, a); chk("bp_accept_b", 32'(a), 1);
    r = rand_req();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, r, 1'b0, 1'b0, 1'b0, '0, a);
      chk("bp_in_ready_low", 32'(in_ready_o), 0);
    end
    send(r, 1'b1, 1'b0, '0);
    drain();

    // Flush with two words in flight.
    c = err_count_o;
    r = rand_req(); send(r, 1'b0, 1'b0, '0);
    r = rand_req(); send(r, 1'b0, 1'b0, '0);
    r = rand_req(); drive(1'b1, 1'b1, r, 1'b0, 1'b1, 1'b0, '0, a);
    chk("flush_drops_input", 32'(a), 0);
    idle(1'b1, 1'b1, 1'b0);
    chk("flush_out_valid", 32'(out_valid_o), 0);
    chk("flush_keeps_count", 32'(err_count_o), 32'(c));
    drain();

    // Reset mid-stream.
    r = rand_req(); send(r, 1'b0, 1'b0, '0);
    r = rand_req(); send(r, 1'b0, 1'b0, '0);
    idle(1'b0, 1'b1, 1'b0);
    chk("midrst_out_valid", 32'(out_valid_o), 0);
    idle(1'b1, 1'b1, 1'b0);
    chk("midrst_no_stale", 32'(out_valid_o), 0);
    drain();

    for (int i = 0; i < 2000; i++) begin
      logic rs, fl, ordy, v;
      rs   = ($urandom_range(0, 199) != 0);
      fl   = ($urandom_range(0, 29) == 0);
      ordy = fl ? 1'b0 : ($urandom_range(0, 9) < 7);
      v    = ($urandom_range(0, 3) != 0);
      r    = rand_req();
      drive(rs, v, r, ordy, fl, 1'b0, '0, a);
    end
    drain();

    // Saturation: more than 65535 errored words back to back.
    idle(1'b0, 1'b1, 1'b0);
    r = rand_req(); r.fmt = 3'd6;
    for (int i = 0; i < 65540; i++) drive(1'b1, 1'b1, r, 1'b1, 1'b0, 1'b0, '0, a);
    drain();
    chk("sat_err_count", 32'(err_count_o), 32'hFFFF);
    send(r, 1'b1, 1'b0, '0);
    drain();
    chk("sat_holds", 32'(err_count_o), 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
